thermal_monitor: RTL and testbench
==================================

THERMAL_MONITOR -- requirements
Module: thermal_monitor

Interface
REQ-001 Parameter NUM_CH, default 2: number of CPU thermtrip channels, range 1..16.
REQ-002 Parameter NUM_VR, default 4: number of VR-hot channels, range 1..32.
REQ-003 Parameter TRIP_DLY, default 20: consecutive high samples required to qualify a thermtrip, range 1..(2^CNT_W)-1.
REQ-004 Parameter CNT_W, default 5: width of each per-channel delay counter.
REQ-005 Parameter IDX_W, default 4: width of first_trip_idx; SHALL satisfy 2^IDX_W >= NUM_CH.
REQ-006 clk  in  1  core clock; the block has only this one clock.
REQ-007 pgd_p3v3_stby_async  in  1  asynchronous, active-low reset.
REQ-008 st_steady_pwrok  in  1  high enables VR-hot qualification.
REQ-009 thermtrip_ena  in  1  high enables thermtrip qualification.
REQ-010 pch_pltrst_n  in  1  active-low platform reset; low blocks thermtrip qualification.
REQ-011 cpu_thermtrip_in  in  NUM_CH  raw thermtrip inputs, active high, asynchronous.
REQ-012 trip_mask  in  NUM_CH  per-channel mask; 1 disables that channel.
REQ-013 vr_hot_n  in  NUM_VR  raw VR-hot inputs, active low, asynchronous.
REQ-014 sticky_clr  in  1  single-cycle pulse that clears the sticky and first-trip records.
REQ-015 qual_vr_hot_n  out  NUM_VR  qualified VR-hot flags, active low.
REQ-016 qual_thermtrip  out  NUM_CH  qualified per-channel thermtrip flags.
REQ-017 or_all_thermtrip  out  1  OR of qual_thermtrip.
REQ-018 trip_sticky  out  NUM_CH  latched thermtrip history.
REQ-019 first_trip_vld  out  1  high when first_trip_idx holds a valid capture.
REQ-020 first_trip_idx  out  IDX_W  index of the first channel to qualify.

Function
REQ-021 Each channel SHALL pass cpu_thermtrip_in through a 2-flop synchronizer before the counter; the output is sync_i.
REQ-022 Channel gate: gate_i = thermtrip_ena & pch_pltrst_n & ~trip_mask[i].
REQ-023 At each clk edge where gate_i=0 or sync_i=0, cnt_i and qual_thermtrip[i] SHALL both clear to 0.
REQ-024 At each edge where gate_i=1, sync_i=1 and cnt_i<TRIP_DLY-1, cnt_i SHALL increment by 1.
REQ-025 At each edge where gate_i=1, sync_i=1 and cnt_i=TRIP_DLY-1, qual_thermtrip[i] SHALL be set to 1 and cnt_i SHALL hold, saturating without wrap.
REQ-026 qual_thermtrip[i] SHALL rise on the TRIP_DLY-th consecutive edge at which sync_i=1. It SHALL fall on the first edge at which sync_i=0 or gate_i=0.
REQ-027 A high input lasting fewer than TRIP_DLY consecutive sync samples SHALL produce no qualification. It also SHALL leave no residual count.
REQ-028 or_all_thermtrip SHALL be the combinational OR of the qual_thermtrip flops.
REQ-029 rise_i = qual_thermtrip[i] is set at this edge while it was 0 before the edge.
REQ-030 trip_sticky[i] SHALL set on rise_i and hold until a sticky_clr edge; if rise_i and sticky_clr coincide, the set wins.
REQ-031 qual_vr_hot_n SHALL be vr_hot_n passed through a 2-flop synchronizer, giving 2-cycle latency. The output SHALL be forced all-ones on any edge where st_steady_pwrok=0.

Reset
REQ-032 While pgd_p3v3_stby_async=0, all synchronizers, counters, qual_thermtrip, trip_sticky, first_trip_vld and first_trip_idx SHALL be 0. qual_vr_hot_n SHALL be all-ones.
REQ-033 Asserting reset mid-count SHALL discard the partial count immediately.

Configuration
REQ-034 Macro THERMAL_FIRST_TRIP_EN defined: if first_trip_vld=0 and any rise_i occurs, then first_trip_vld<=1 and first_trip_idx<=lowest i with rise_i. Later rises do not alter the capture. sticky_clr clears both, and a simultaneous rise wins.
REQ-035 Macro THERMAL_FIRST_TRIP_EN not defined: no capture logic is built, and first_trip_vld and first_trip_idx are tied to 0.

Verification
REQ-036 TRIP_DLY=20; ena=1, pltrst_n=1; ch0 held high -> qual_thermtrip[0] rises on the 20th edge after sync output goes high, and or_all_thermtrip=1 in the same cycle.
REQ-037 ch1 high for 19 sync samples, low for 1, then high for 20 -> no qualification after the first burst; qualification on the 20th sample of the second burst.
REQ-038 ch0 qualified, then pch_pltrst_n=0 -> qual_thermtrip[0]=0 on the next edge and trip_sticky[0] stays 1. sticky_clr pulse -> trip_sticky[0]=0.
REQ-039 With THERMAL_FIRST_TRIP_EN defined: ch1 and ch0 qualify on the same edge -> first_trip_idx=0. A later ch2 rise leaves idx=0. sticky_clr coincident with a ch3 rise -> vld=1, idx=3.
REQ-040 vr_hot_n[2]=0 with st_steady_pwrok=1 -> qual_vr_hot_n[2]=0 after 2 edges. Drop st_steady_pwrok -> all-ones next edge. Assert reset mid-count at cnt=10, release, hold ch0 high -> the full 20 samples are required again.

Source files
------------

// File: rtl/thermal_monitor.sv
// thermal_monitor: qualifies CPU thermtrip and VR-hot inputs and keeps a thermtrip history.
//
// Optional feature: define THERMAL_FIRST_TRIP_EN to build first-trip capture
// (first_trip_vld/first_trip_idx); otherwise both outputs are tied to 0.
//
// Ports:
//   clk                  core clock (only clock)
//   pgd_p3v3_stby_async  asynchronous active-low reset
//   st_steady_pwrok      high enables VR-hot qualification
//   thermtrip_ena        high enables thermtrip qualification
//   pch_pltrst_n         active-low platform reset, low blocks thermtrip qualification
//   cpu_thermtrip_in     raw per-channel thermtrip inputs (async, active high)
//   trip_mask            per-channel mask, 1 disables the channel
//   vr_hot_n             raw VR-hot inputs (async, active low)
//   sticky_clr           one-cycle pulse clearing sticky and first-trip records
//   qual_vr_hot_n        synchronized VR-hot flags, all-ones while not power-ok
//   qual_thermtrip       per-channel qualified thermtrip
//   or_all_thermtrip     OR of qual_thermtrip
//   trip_sticky          latched thermtrip history
//   first_trip_vld       first_trip_idx holds a valid capture
//   first_trip_idx       lowest channel that qualified first
module thermal_monitor #(
    parameter int NUM_CH   = 2,
    parameter int NUM_VR   = 4,
    parameter int TRIP_DLY = 20,
    parameter int CNT_W    = 5,
    parameter int IDX_W    = 4
) (
    input  logic              clk,
    input  logic              pgd_p3v3_stby_async,
    input  logic              st_steady_pwrok,
    input  logic              thermtrip_ena,
    input  logic              pch_pltrst_n,
    input  logic [NUM_CH-1:0] cpu_thermtrip_in,
    input  logic [NUM_CH-1:0] trip_mask,
    input  logic [NUM_VR-1:0] vr_hot_n,
    input  logic              sticky_clr,
    output logic [NUM_VR-1:0] qual_vr_hot_n,
    output logic [NUM_CH-1:0] qual_thermtrip,
    output logic              or_all_thermtrip,
    output logic [NUM_CH-1:0] trip_sticky,
    output logic              first_trip_vld,
    output logic [IDX_W-1:0]  first_trip_idx
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TRIP_DLY - 1);

    logic [NUM_CH-1:0]            trip_s1_q, trip_s2_q, qual_q, qual_d, sticky_q, sticky_d, gate, rise;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_VR-1:0]            vr_s1_q, vr_s2_q;

    assign gate = {NUM_CH{thermtrip_ena & pch_pltrst_n}} & ~trip_mask;

    // Counter saturates at CNT_MAX; the qualified flag is set on the edge that finds it there.
    always_comb begin
        cnt_d  = '0;
        qual_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gate[i] && trip_s2_q[i]) begin
                cnt_d[i]  = (cnt_q[i] < CNT_MAX) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
                qual_d[i] = (cnt_q[i] == CNT_MAX);
            end
        end
    end

    assign rise     = qual_d & ~qual_q;
    assign sticky_d = rise | (sticky_q & ~{NUM_CH{sticky_clr}});

    always_ff @(posedge clk or negedge pgd_p3v3_stby_async) begin
        if (!pgd_p3v3_stby_async) begin
            trip_s1_q <= '0;
            trip_s2_q <= '0;
            cnt_q     <= '0;
            qual_q    <= '0;
            sticky_q  <= '0;
            vr_s1_q   <= '1;
            vr_s2_q   <= '1;
        end else begin
            trip_s1_q <= cpu_thermtrip_in;
            trip_s2_q <= trip_s1_q;
            cnt_q     <= cnt_d;
            qual_q    <= qual_d;
            sticky_q  <= sticky_d;
            vr_s1_q   <= vr_hot_n;
            vr_s2_q   <= st_steady_pwrok ? vr_s1_q : '1;
        end
    end

    assign qual_vr_hot_n    = vr_s2_q;
    assign qual_thermtrip   = qual_q;
    assign or_all_thermtrip = |qual_q;
    assign trip_sticky      = sticky_q;

`ifdef THERMAL_FIRST_TRIP_EN
    logic             vld_q, vld_d;
    logic [IDX_W-1:0] idx_q, idx_d, low_idx;

    // Scan downward so the lowest rising channel is the one left in low_idx.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rise[i]) low_idx = IDX_W'(i);
        end
        vld_d = (|rise) | (vld_q & ~sticky_clr);
        idx_d = ((|rise) && (sticky_clr || !vld_q)) ? low_idx : (sticky_clr ? '0 : idx_q);
    end

    always_ff @(posedge clk or negedge pgd_p3v3_stby_async) begin
        if (!pgd_p3v3_stby_async) begin
            vld_q <= 1'b0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign first_trip_vld = vld_q;
    assign first_trip_idx = idx_q;
`else
    assign first_trip_vld = 1'b0;
    assign first_trip_idx = '0;
`endif

endmodule

// File: tb/tb_thermal_monitor.sv
// tb_thermal_monitor: directed and randomized checks of thermal_monitor against a run-length reference model.
module tb_thermal_monitor;
    localparam int NUM_CH   = 4;
    localparam int NUM_VR   = 4;
    localparam int TRIP_DLY = 20;
    localparam int CNT_W    = 5;
    localparam int IDX_W    = 4;
`ifdef THERMAL_FIRST_TRIP_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pwrok = 1'b0;
    logic              ena = 1'b0;
    logic              pltrst_n = 1'b0;
    logic              clr = 1'b0;
    logic [NUM_CH-1:0] trip_in = '0;
    logic [NUM_CH-1:0] mask = '0;
    logic [NUM_VR-1:0] vr_n = '1;
    logic [NUM_VR-1:0] qual_vr;
    logic [NUM_CH-1:0] qual, sticky;
    logic              or_all, vld;
    logic [IDX_W-1:0]  idx;

    int n_cmp = 0;
    int n_err = 0;

    thermal_monitor #(.NUM_CH(NUM_CH), .NUM_VR(NUM_VR), .TRIP_DLY(TRIP_DLY), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .pgd_p3v3_stby_async(rst_n), .st_steady_pwrok(pwrok), .thermtrip_ena(ena),
        .pch_pltrst_n(pltrst_n), .cpu_thermtrip_in(trip_in), .trip_mask(mask), .vr_hot_n(vr_n),
        .sticky_clr(clr), .qual_vr_hot_n(qual_vr), .qual_thermtrip(qual), .or_all_thermtrip(or_all),
        .trip_sticky(sticky), .first_trip_vld(vld), .first_trip_idx(idx)
    );

    always #5 clk = ~clk;

    // Reference model: a channel qualifies once it has seen TRIP_DLY consecutive
    // gated samples of the input as it stood two edges earlier.
    int                m_run [NUM_CH];
    logic [NUM_CH-1:0] m_h1, m_h2, m_qual, m_sticky, m_rise, m_prev;
    logic              m_vld;
    logic [IDX_W-1:0]  m_idx;
    logic [NUM_VR-1:0] m_vr, m_vrp;

    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (m_run[i]) m_run[i] = 0;
            m_h1 = '0; m_h2 = '0; m_qual = '0; m_sticky = '0;
            m_vld = 1'b0; m_idx = '0; m_vr = '1; m_vrp = '1;
        end else begin
            m_prev = m_qual;
            for (int i = 0; i < NUM_CH; i++) begin
                m_run[i] = (ena && pltrst_n && !mask[i] && m_h2[i]) ? m_run[i] + 1 : 0;
                m_qual[i] = (m_run[i] >= TRIP_DLY);
            end
            m_rise = m_qual & ~m_prev;
            m_sticky = m_rise | (clr ? '0 : m_sticky);
            if ((clr || !m_vld) && m_rise != '0) begin
                m_vld = 1'b1;
                for (int i = NUM_CH - 1; i >= 0; i--) if (m_rise[i]) m_idx = IDX_W'(i);
            end else if (clr) begin
                m_vld = 1'b0;
                m_idx = '0;
            end
            m_vr = pwrok ? m_vrp : '1;
            m_vrp = vr_n;
            m_h2 = m_h1;
            m_h1 = trip_in;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle;
        trip_in = '0; mask = '0; ena = 1'b1; pltrst_n = 1'b1; pwrok = 1'b1;
        tick(3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset;
        tick(2);
        n_cmp++; if (qual !== '0 || or_all !== 1'b0) begin n_err++; $display("FAIL reset_qual: got %b/%b want 0/0", qual, or_all); end
        n_cmp++; if (sticky !== '0) begin n_err++; $display("FAIL reset_sticky: got %b want 0", sticky); end
        n_cmp++; if (vld !== 1'b0 || idx !== '0) begin n_err++; $display("FAIL reset_first: got %b/%0d want 0/0", vld, idx); end
        n_cmp++; if (qual_vr !== '1) begin n_err++; $display("FAIL reset_vr: got %b want 1111", qual_vr); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_qualify;
        settle();
        trip_in[0] = 1'b1;
        tick(21);
        n_cmp++; if (qual[0] !== 1'b0) begin n_err++; $display("FAIL qualify_early: got %b want 0", qual[0]); end
        tick();
        n_cmp++; if (qual !== 4'b0001) begin n_err++; $display("FAIL qualify_edge: got %b want 0001", qual); end
        n_cmp++; if (or_all !== 1'b1) begin n_err++; $display("FAIL qualify_or: got %b want 1", or_all); end
        n_cmp++; if (sticky !== 4'b0001) begin n_err++; $display("FAIL qualify_sticky: got %b want 0001", sticky); end
    endtask

    task automatic test_glitch;
        logic seen;
        settle();
        seen = 1'b0;
        trip_in[1] = 1'b1;
        tick(19);
        trip_in[1] = 1'b0;
        tick();
        trip_in[1] = 1'b1;
        for (int k = 0; k < 21; k++) begin
            tick();
            seen |= qual[1];
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL glitch_no_qual: got %b want 0", seen); end
        tick();
        n_cmp++; if (qual[1] !== 1'b1) begin n_err++; $display("FAIL glitch_second_burst: got %b want 1", qual[1]); end
    endtask

    task automatic test_pltrst;
        settle();
        trip_in[0] = 1'b1;
        tick(22);
        pltrst_n = 1'b0;
        tick();
        n_cmp++; if (qual[0] !== 1'b0) begin n_err++; $display("FAIL pltrst_qual: got %b want 0", qual[0]); end
        n_cmp++; if (sticky[0] !== 1'b1) begin n_err++; $display("FAIL pltrst_sticky: got %b want 1", sticky[0]); end
        pltrst_n = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (sticky[0] !== 1'b0) begin n_err++; $display("FAIL sticky_clear: got %b want 0", sticky[0]); end
    endtask

    task automatic test_first_trip;
        settle();
        trip_in[1:0] = 2'b11;
        tick(22);
        n_cmp++; if (vld !== FT || idx !== '0) begin n_err++; $display("FAIL first_same_edge: got %b/%0d want %b/0", vld, idx, FT); end
        trip_in[2] = 1'b1;
        tick(22);
        n_cmp++; if (qual[2] !== 1'b1 || vld !== FT || idx !== '0) begin n_err++; $display("FAIL first_later_rise: got %b/%b/%0d want 1/%b/0", qual[2], vld, idx, FT); end
        trip_in[3] = 1'b1;
        tick(21);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (vld !== FT || idx !== (FT ? IDX_W'(3) : '0)) begin n_err++; $display("FAIL first_clr_rise: got %b/%0d want %b/%0d", vld, idx, FT, FT ? 3 : 0); end
        n_cmp++; if (sticky !== 4'b1000) begin n_err++; $display("FAIL clr_rise_sticky: got %b want 1000", sticky); end
    endtask

    task automatic test_vr;
        settle();
        vr_n = 4'b1011;
        tick();
        n_cmp++; if (qual_vr !== 4'b1111) begin n_err++; $display("FAIL vr_latency1: got %b want 1111", qual_vr); end
        tick();
        n_cmp++; if (qual_vr !== 4'b1011) begin n_err++; $display("FAIL vr_latency2: got %b want 1011", qual_vr); end
        pwrok = 1'b0;
        tick();
        n_cmp++; if (qual_vr !== 4'b1111) begin n_err++; $display("FAIL vr_pwrok_drop: got %b want 1111", qual_vr); end
        pwrok = 1'b1;
        vr_n = '1;
        tick(2);
    endtask

    task automatic test_reset_midcount;
        settle();
        trip_in[0] = 1'b1;
        tick(12);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (qual !== '0 || sticky !== '0 || vld !== 1'b0 || qual_vr !== '1) begin n_err++; $display("FAIL async_reset: got %b/%b/%b/%b want 0/0/0/1111", qual, sticky, vld, qual_vr); end
        tick(2);
        rst_n = 1'b1;
        tick(21);
        n_cmp++; if (qual[0] !== 1'b0) begin n_err++; $display("FAIL midcount_discard: got %b want 0", qual[0]); end
        tick();
        n_cmp++; if (qual[0] !== 1'b1) begin n_err++; $display("FAIL midcount_requal: got %b want 1", qual[0]); end
    endtask

    task automatic test_random;
        settle();
        for (int c = 0; c < 4000; c++) begin
            tick();
            n_cmp++; if (qual !== m_qual || or_all !== |m_qual) begin n_err++; $display("FAIL rnd_qual @%0d: got %b/%b want %b/%b", c, qual, or_all, m_qual, |m_qual); end
            n_cmp++; if (sticky !== m_sticky) begin n_err++; $display("FAIL rnd_sticky @%0d: got %b want %b", c, sticky, m_sticky); end
            n_cmp++; if (qual_vr !== m_vr) begin n_err++; $display("FAIL rnd_vr @%0d: got %b want %b", c, qual_vr, m_vr); end
            n_cmp++; if (vld !== (FT & m_vld) || idx !== (FT ? m_idx : '0)) begin n_err++; $display("FAIL rnd_first @%0d: got %b/%0d want %b/%0d", c, vld, idx, FT & m_vld, FT ? m_idx : '0); end
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(29) == 0) trip_in[i] = ~trip_in[i];
                if ($urandom_range(299) == 0) mask[i] = ~mask[i];
            end
            for (int i = 0; i < NUM_VR; i++) if ($urandom_range(9) == 0) vr_n[i] = ~vr_n[i];
            if ($urandom_range(199) == 0) ena = ~ena;
            if ($urandom_range(199) == 0) pltrst_n = ~pltrst_n;
            if ($urandom_range(99) == 0) pwrok = ~pwrok;
            clr = ($urandom_range(49) == 0);
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_qualify();
        test_glitch();
        test_pltrst();
        test_first_trip();
        test_vr();
        test_reset_midcount();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
